bin_to_bcd_fmt: RTL and testbench

//   Converts the calculator's unsigned binary result into packed BCD.
//   The packed BCD drives the 16-bit displayed_num input of the 4-digit seven-segment driver.

---
 rtl/bin_to_bcd_fmt.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_fmt.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_fmt.sv
// Binary-to-packed-BCD converter for the calculator display, using an iterative
// shift-add-3 engine behind a start/done handshake; out-of-range values show as all ERR_NIBBLE.
module bin_to_bcd_fmt #(
  parameter int         WIDTH      = 16,
  parameter int         DIGITS     = 4,
  parameter int         MAX_VAL    = 9999,
  parameter logic [3:0] ERR_NIBBLE = 4'hE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   displayed_num
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_VAL_W = WIDTH'(MAX_VAL);
  localparam logic [CNTW-1:0]  LAST_CNT  = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      shift_q;
  logic [BCDW-1:0]       scratch_q;
  logic [CNTW-1:0]       cnt_q;
  logic                  ovfPend_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overflow_q;
  logic [BCDW-1:0]       display_q;

  logic [BCDW-1:0]       scratchAdj_d;
  logic [BCDW+WIDTH-1:0] shiftNext_d;

  // One double-dabble step: correct every digit >= 5, then shift the whole chain left.
  // The bit leaving the top digit is dropped; that only happens for values above MAX_VAL.
  always_comb begin
    scratchAdj_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratchAdj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shiftNext_d = {scratchAdj_d, shift_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovfPend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      display_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovfPend_q <= (bin_in > MAX_VAL_W);
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          scratch_q <= shiftNext_d[BCDW+WIDTH-1:WIDTH];
          shift_q   <= shiftNext_d[WIDTH-1:0];
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          // The display only ever sees a finished result, never the scratch in flight.
          display_q  <= ovfPend_q ? {DIGITS{ERR_NIBBLE}} : scratch_q;
          overflow_q <= ovfPend_q;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign displayed_num = display_q;

endmodule

// File: tb/tb_bin_to_bcd_fmt.sv
// Directed self-checking bench for bin_to_bcd_fmt: latency, boundaries, ignored starts,
// mid-conversion reset, and a back-to-back sweep against a decimal reference model.
module tb_bin_to_bcd_fmt;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] displayed_num;

  int          vectors;
  int          miscompares;
  int          stableErr;
  logic [15:0] lastShown;

  bin_to_bcd_fmt dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bin_in       (bin_in),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .displayed_num(displayed_num)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] refBcd(input int v);
    if (v > 9999) return 16'hEEEE;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge; bin_in is scrambled afterwards to show it no longer matters.
  task automatic applyStimulus(input logic [15:0] val);
    start  = 1'b1;
    bin_in = val;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 16'($urandom);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic waitDone(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
      else if (displayed_num !== lastShown) stableErr++;
    end
  endtask

  task automatic convertAndCheck(input string tag, input int val);
    int edges;
    bit seen;
    applyStimulus(16'(val));
    waitDone(edges, seen);
    checkOutput({tag, "_done"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_latency"}, edges, 32'd17);
    checkOutput({tag, "_value"}, {16'd0, displayed_num}, {16'd0, refBcd(val)});
    checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, val > 9999});
    lastShown = refBcd(val);
    @(posedge clk); #1;
    checkOutput({tag, "_done_single"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int  edges;
    int  pulses;
    bit  seen;
    int  vals [200];

    vectors     = 0;
    miscompares = 0;
    stableErr   = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_disp", {16'd0, displayed_num}, 32'h0);
    reset     = 1'b0;
    lastShown = 16'h0000;
    @(posedge clk); #1;

    $display("[TB] basic conversions and boundaries");
    convertAndCheck("c1234", 1234);
    convertAndCheck("c9999", 9999);
    convertAndCheck("c10000", 10000);
    convertAndCheck("c65535", 65535);

    $display("[TB] start during conversion is ignored");
    applyStimulus(16'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start  = 1'b1;
    bin_in = 16'd42;
    @(posedge clk); #1;
    start  = 1'b0;
    waitDone(edges, seen);
    checkOutput("ign_done", {31'd0, seen}, 32'd1);
    checkOutput("ign_latency", edges + 5, 32'd17);
    checkOutput("ign_value", {16'd0, displayed_num}, 32'h0000);
    checkOutput("ign_ovf", {31'd0, overflow}, 32'd0);
    lastShown = 16'h0000;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checkOutput("ign_extra_done", pulses, 32'd0);
    checkOutput("ign_value_hold", {16'd0, displayed_num}, 32'h0000);

    $display("[TB] reset mid-conversion");
    convertAndCheck("pre_rst", 10000);
    applyStimulus(16'd4321);
    repeat (7) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lastShown = 16'h0000;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_disp", {16'd0, displayed_num}, 32'h0000);
    checkOutput("abort_ovf", {31'd0, overflow}, 32'd0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 32'd0);
    checkOutput("abort_disp_hold", {16'd0, displayed_num}, 32'h0000);
    convertAndCheck("post_rst", 5678);
    convertAndCheck("c0", 0);

    $display("[TB] back-to-back sweep");
    foreach (vals[i]) vals[i] = $urandom_range(9999, 0);
    vals[0] = 1;
    vals[1] = 9990;
    vals[2] = 505;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(16'(vals[i]));
      waitDone(edges, seen);
      checkOutput("sweep_done", {31'd0, seen}, 32'd1);
      checkOutput("sweep_latency", edges, 32'd17);
      checkOutput($sformatf("sweep_%0d", vals[i]), {16'd0, displayed_num},
                  {16'd0, refBcd(vals[i])});
      lastShown = refBcd(vals[i]);
    end
    checkOutput("sweep_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("display_stable", stableErr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
